hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. Generates stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC redirect. Covers load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits, including redirects that arrive during a memory wait. Also keeps hazard performance counters and a memory-wait watchdog.

Parameters:
CNT_W, 32, width of saturating performance counters
MAX_WAIT, 64, memory-wait cycles before timeout_err sets (>=1)

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_mem_read  in  1  instruction in EX is a load
branch_taken  in  1  one-cycle pulse from EX: taken branch/jump
branch_target  in  32  redirect PC, valid with branch_taken
dmem_busy  in  1  data memory not ready; MEM stage must hold
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  load NOP into IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  insert bubble into ID/EX
ex_mem_stall  out  1  hold EX/MEM
pc_redirect  out  1  PC loads redirect_pc next edge
redirect_pc  out  32  redirect address
timeout_err  out  1  sticky: memory wait exceeded MAX_WAIT
stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating
flush_events  out  CNT_W  cycles with if_id_flush=1, saturating

Behaviour:
- Reset (reset_n=0, async): state=RUN, pending=0, saved target=0, wait_cnt=0, timeout_err=0, counters=0. All control outputs and redirect_pc read 0 while reset_n=0.
- States: RUN, MEM_WAIT, REDIRECT. Control outputs are combinational from state and current inputs. Registers update on the rising edge.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN: dmem_busy > branch_taken > load_use.
- RUN, dmem_busy=1:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall all =1; all flushes=0.
  - If branch_taken is also 1, pending<=1 and target<=branch_target.
  - Next state MEM_WAIT.
- RUN, branch_taken=1:
  - if_id_flush=1, id_ex_flush=1, pc_redirect=1, redirect_pc=branch_target, same cycle. Any load_use is ignored (wrong-path instruction).
  - Stay RUN.
- RUN, load_use=1:
  - pc_stall=1, if_id_stall=1, id_ex_flush=1; others 0.
  - Exactly one bubble per occurrence, because the load leaves EX on the next edge.
  - Stay RUN.
- RUN, none of the above: all controls 0.
- MEM_WAIT, dmem_busy=1:
  - All four stalls=1.
  - branch_taken updates pending/target (last pulse wins).
  - wait_cnt increments, saturating at MAX_WAIT. When wait_cnt reaches MAX_WAIT, timeout_err<=1; it stays 1 until reset. Timeout has no effect on the stalls.
- MEM_WAIT, dmem_busy=0:
  - wait_cnt<=0.
  - If pending (or branch_taken this cycle): next state REDIRECT. Outputs this cycle are all 0.
  - Otherwise: next state RUN. Outputs this cycle follow the RUN rules for load_use only.
- REDIRECT (exactly 1 cycle):
  - if_id_flush=1, id_ex_flush=1, pc_redirect=1, redirect_pc=saved target. pending<=0, next state RUN.
  - If dmem_busy=1 here, the stalls take priority: all four stalls=1, no flush, stay REDIRECT with pending held.
- redirect_pc = 0 whenever pc_redirect=0.
- Counters: stall_cycles += pc_stall; flush_events += if_id_flush. Both hold at all-ones.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 for exactly that cycle; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Branch beats load-use: branch_taken=1, branch_target=0x0000_0100, load_use true -> if_id_flush=id_ex_flush=pc_redirect=1, redirect_pc=0x100, pc_stall=0; flush_events=1.
- Memory wait: dmem_busy=1 for 3 cycles -> all four stalls=1 for 3 cycles, no flushes, then all 0; stall_cycles=3.
- Redirect during wait: dmem_busy=1 for 4 cycles, branch_taken pulse (target 0x200) in cycle 2 -> no flush while busy; release cycle all 0; next cycle pc_redirect=1, redirect_pc=0x200, both flushes=1; then RUN.
- Watchdog: MAX_WAIT=4, dmem_busy held 6 cycles -> timeout_err rises after the 4th busy cycle, stays 1 after busy drops, clears only on reset_n=0.
- Async reset mid-REDIRECT: drop reset_n between edges -> all outputs 0 immediately; after release, no redirect occurs; counters=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer with memory-wait watchdog and hazard counters.
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t state, state_nxt;
  logic pending, pending_nxt;
  logic [31:0] target, target_nxt, rpc;
  logic [WW-1:0] wait_cnt, wait_inc;
  logic load_use, stall_all, lu_stall, flush;
  assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    target_nxt  = target;
    stall_all   = 1'b0;
    lu_stall    = 1'b0;
    flush       = 1'b0;
    rpc         = 32'd0;
    unique case (state)
      RUN: begin
        if (dmem_busy) begin
          stall_all = 1'b1;
          state_nxt = MEM_WAIT;
          pending_nxt = pending | branch_taken;
          target_nxt  = branch_taken ? branch_target : target;
        end else if (branch_taken) begin
          flush = 1'b1;
          rpc   = branch_target;
        end else lu_stall = load_use;
      end
      MEM_WAIT: begin
        pending_nxt = pending | branch_taken;
        target_nxt  = branch_taken ? branch_target : target;
        if (dmem_busy) stall_all = 1'b1;
        else if (pending || branch_taken) state_nxt = REDIRECT;
        else begin
          state_nxt = RUN;
          lu_stall  = load_use;
        end
      end
      REDIRECT: begin
        if (dmem_busy) stall_all = 1'b1;
        else begin
          flush       = 1'b1;
          rpc         = target;
          pending_nxt = 1'b0;
          state_nxt   = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end
  // Outputs are forced low while reset is asserted, independent of the clock.
  assign pc_stall     = reset_n & (stall_all | lu_stall);
  assign if_id_stall  = reset_n & (stall_all | lu_stall);
  assign id_ex_stall  = reset_n & stall_all;
  assign ex_mem_stall = reset_n & stall_all;
  assign if_id_flush  = reset_n & flush;
  assign id_ex_flush  = reset_n & (flush | lu_stall);
  assign pc_redirect  = reset_n & flush;
  assign redirect_pc  = {32{reset_n & flush}} & rpc;
  assign wait_inc = wait_cnt + WW'(wait_cnt != WW'(MAX_WAIT));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      pending      <= 1'b0;
      target       <= 32'd0;
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      target       <= target_nxt;
      wait_cnt     <= dmem_busy ? wait_inc : '0;
      timeout_err  <= timeout_err | (dmem_busy && wait_inc == WW'(MAX_WAIT));
      stall_cycles <= stall_cycles + CNT_W'(pc_stall && !(&stall_cycles));
      flush_events <= flush_events + CNT_W'(if_id_flush && !(&flush_events));
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench with a cycle-level reference model and randomized hazards.
module tb_hazard_ctrl;
  localparam int CNT_W = 8;
  localparam int MAX_WAIT = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [6:0] STALL = 7'b1101010;
  localparam logic [6:0] FLUSH = 7'b0010101;
  localparam logic [6:0] LU    = 7'b1100100;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, branch_taken = 0, dmem_busy = 0;
  logic [31:0] branch_target = '0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, pc_redirect;
  logic [31:0] redirect_pc;
  logic timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  always #5 clk = ~clk;
  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_busy(dmem_busy), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles), .flush_events(flush_events));
  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] rpc;
    logic        tmo;
    int          sc;
    int          fe;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  bit m_wait, m_redir, m_pend, m_tmo;
  logic [31:0] m_tgt;
  int m_run, m_sc, m_fe;
  logic [6:0] last_ctrl;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    m_wait = 0; m_redir = 0; m_pend = 0; m_tmo = 0; m_tgt = '0;
    m_run = 0; m_sc = 0; m_fe = 0; last_ctrl = '0;
  endfunction
  // Advance the model across one rising edge using the inputs the DUT just sampled.
  function automatic void model_step();
    if (last_ctrl[6] && m_sc < CMAX) m_sc++;
    if (last_ctrl[4] && m_fe < CMAX) m_fe++;
    m_run = dmem_busy ? m_run + 1 : 0;
    if (m_run >= MAX_WAIT) m_tmo = 1;
    if (m_redir) begin
      if (!dmem_busy) begin m_redir = 0; m_pend = 0; end
    end else if (m_wait) begin
      if (branch_taken) begin m_pend = 1; m_tgt = branch_target; end
      if (!dmem_busy) begin m_wait = 0; m_redir = m_pend; end
    end else if (dmem_busy) begin
      m_wait = 1;
      if (branch_taken) begin m_pend = 1; m_tgt = branch_target; end
    end
  endfunction
  function automatic exp_t model_out();
    exp_t e;
    bit lu;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e.rpc = '0;
    if (m_redir) begin
      e.ctrl = dmem_busy ? STALL : FLUSH;
      if (!dmem_busy) e.rpc = m_tgt;
    end else if (dmem_busy) e.ctrl = STALL;
    else if (m_wait) e.ctrl = (m_pend || branch_taken) ? 7'd0 : (lu ? LU : 7'd0);
    else if (branch_taken) begin
      e.ctrl = FLUSH;
      e.rpc  = branch_target;
    end else e.ctrl = lu ? LU : 7'd0;
    e.tmo = m_tmo; e.sc = m_sc; e.fe = m_fe;
    return e;
  endfunction
  task automatic cyc(input bit b, input bit br, input logic [31:0] bt, input bit rdm,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit u1, input bit u2);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    dmem_busy = b; branch_taken = br; branch_target = bt; ex_mem_read = rdm;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    e = model_out();
    last_ctrl = e.ctrl;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic do_reset();
    #1;
    q.delete();
    reset_n = 0;
    dmem_busy = 0; branch_taken = 0; branch_target = '0; ex_mem_read = 0;
    ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    #1;
    chk("rst_ctrl", 32'({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                         ex_mem_stall, pc_redirect}), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_cnt", 32'({stall_cycles, flush_events}), 0);
    @(posedge clk);
    #2;
    model_reset();
    reset_n = 1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctrl", 32'({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                       ex_mem_stall, pc_redirect}), 32'(e.ctrl));
      chk("redirect_pc", redirect_pc, e.rpc);
      chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
      chk("stall_cycles", 32'(stall_cycles), e.sc);
      chk("flush_events", 32'(flush_events), e.fe);
    end
  end
  initial begin
    int burst;
    bit b, br;
    do_reset();
    cyc(0, 0, 0, 1, 5, 5, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 1);
    idle(1);
    cyc(0, 1, 32'h100, 1, 5, 5, 0, 1, 0);
    idle(2);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    do_reset();
    repeat (6) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    do_reset();
    idle(2);
    cyc(1, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);
    burst = 0;
    for (int i = 0; i < 900; i++) begin
      if (burst == 0 && $urandom_range(99) < 15) burst = $urandom_range(7, 1);
      b = burst > 0;
      if (burst > 0) burst--;
      br = $urandom_range(99) < 15;
      cyc(b, br, $urandom, $urandom_range(1), 5'($urandom_range(3)), 5'($urandom_range(3)),
          5'($urandom_range(3)), $urandom_range(1), $urandom_range(1));
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
